// File: rtl/multicast_demux_if.sv
// Packet, flow-control and table-config bundle of the multicast fan-out stage.
interface multicast_demux_if #(
  parameter int unsigned DataWidth  = 256,
  parameter int unsigned IndexWidth = 8
);
  logic [DataWidth-1:0]  in;
  logic                  in_avail;
  logic [6:0]            out_avail;
  logic [DataWidth-1:0]  out_local;
  logic [DataWidth-1:0]  out_yneg;
  logic [DataWidth-1:0]  out_ypos;
  logic [DataWidth-1:0]  out_xpos;
  logic [DataWidth-1:0]  out_xneg;
  logic [DataWidth-1:0]  out_zpos;
  logic [DataWidth-1:0]  out_zneg;
  logic                  cfg_we;
  logic [IndexWidth-1:0] cfg_addr;
  logic [6:0]            cfg_mask;
  logic [15:0]           drop_cnt;

  modport slave (
    input  in, out_avail, cfg_we, cfg_addr, cfg_mask,
    output in_avail, out_local, out_yneg, out_ypos, out_xpos, out_xneg, out_zpos, out_zneg,
    output drop_cnt
  );

  modport master (
    output in, out_avail, cfg_we, cfg_addr, cfg_mask,
    input  in_avail, out_local, out_yneg, out_ypos, out_xpos, out_xneg, out_zpos, out_zneg,
    input  drop_cnt
  );
endinterface

// File: rtl/multicast_demux.sv
// One-to-seven packet fan-out: lookup stage A, then send stage S that replicates a packet
// to every port in its mask, retrying blocked ports until all copies have left.
module multicast_demux #(
  parameter int unsigned DataWidth       = 256,
  parameter int unsigned MulticastBitPos = 253,
  parameter int unsigned IndexPos        = 128,
  parameter int unsigned IndexWidth      = 8,
  parameter int unsigned ExitPos         = 160,
  parameter int unsigned ExitWidth       = 4,
  parameter int unsigned NumPorts        = 7
) (
  input  logic              clk,
  input  logic              rst,
  multicast_demux_if.slave  bus
);
  localparam int unsigned TableDepth = 2 ** IndexWidth;

  logic                  r_a_valid;
  logic [DataWidth-1:0]  r_a_pkt;
  logic [NumPorts-1:0]   r_a_mask;
  logic                  r_s_valid;
  logic [DataWidth-1:0]  r_s_pkt;
  logic [NumPorts-1:0]   r_s_rem;
  logic [DataWidth-1:0]  r_out [NumPorts];
  logic [15:0]           r_drop_cnt;
  logic [NumPorts-1:0]   r_table [TableDepth];

  logic [ExitWidth-1:0]  w_exit;
  logic [IndexWidth-1:0] w_idx;
  logic [NumPorts-1:0]   w_a_rem;
  logic [NumPorts-1:0]   w_grant;
  logic                  w_s_free_next;
  logic                  w_a_move;
  logic                  w_a_drop;
  logic                  w_in_avail;
  logic                  w_accept;

  assign w_exit = r_a_pkt[ExitPos +: ExitWidth];
  assign w_idx  = bus.in[IndexPos +: IndexWidth];

  // Unicast exits outside 0..NumPorts-1 decode to an empty mask and are dropped.
  always_comb begin
    w_a_rem = '0;
    if (r_a_pkt[MulticastBitPos]) begin
      w_a_rem = r_a_mask;
    end else begin
      for (int p = 0; p < int'(NumPorts); p++) begin
        if (w_exit == ExitWidth'(p)) w_a_rem[p] = 1'b1;
      end
    end
  end

  assign w_grant       = r_s_valid ? (r_s_rem & bus.out_avail) : '0;
  assign w_s_free_next = !r_s_valid || ((r_s_rem & ~bus.out_avail) == '0);
  assign w_a_move      = r_a_valid && w_s_free_next;
  assign w_a_drop      = (w_a_rem == '0);
  assign w_in_avail    = !r_a_valid || w_s_free_next;
  assign w_accept      = bus.in[DataWidth-1] && w_in_avail;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a_valid <= 1'b0;
      r_a_pkt   <= '0;
      r_a_mask  <= '0;
    end else if (w_accept) begin
      r_a_valid <= 1'b1;
      r_a_pkt   <= bus.in;
      r_a_mask  <= r_table[w_idx];
    end else if (w_a_move) begin
      r_a_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s_valid <= 1'b0;
      r_s_pkt   <= '0;
      r_s_rem   <= '0;
    end else if (w_a_move && !w_a_drop) begin
      r_s_valid <= 1'b1;
      r_s_pkt   <= r_a_pkt;
      r_s_rem   <= w_a_rem;
    end else if (w_s_free_next) begin
      r_s_valid <= 1'b0;
      r_s_rem   <= '0;
    end else begin
      r_s_rem   <= r_s_rem & ~w_grant;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int p = 0; p < int'(NumPorts); p++) r_out[p] <= '0;
    end else begin
      for (int p = 0; p < int'(NumPorts); p++) r_out[p] <= w_grant[p] ? r_s_pkt : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_drop_cnt <= '0;
    end else if (w_a_move && w_a_drop) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  // Lookup reads the pre-write contents when cfg targets the same entry on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(TableDepth); i++) r_table[i] <= '0;
    end else if (bus.cfg_we) begin
      r_table[bus.cfg_addr] <= bus.cfg_mask;
    end
  end

  assign bus.in_avail  = w_in_avail;
  assign bus.drop_cnt  = r_drop_cnt;
  assign bus.out_local = r_out[0];
  assign bus.out_yneg  = r_out[1];
  assign bus.out_ypos  = r_out[2];
  assign bus.out_xpos  = r_out[3];
  assign bus.out_xneg  = r_out[4];
  assign bus.out_zpos  = r_out[5];
  assign bus.out_zneg  = r_out[6];
endmodule

// File: doc/multicast_demux.md
Name: multicast_demux

Overview:
- One-to-seven fan-out stage of the 7-router crossbar switch; the distribution counterpart of the 7-to-1 priority/reduction merge stage.
- Takes the single packet stream leaving a switch output and dispatches each packet to one or more of seven output ports (local, yneg, ypos, xpos, xneg, zpos, zneg).
- Unicast packets go to the port named in the exit field. Multicast packets are replicated per a port mask held in an on-chip multicast table.
- Replication is partial: copies go to ready ports immediately, and blocked ports are retried until done.

Parameters:
- DataWidth, 256, packet width; bit DataWidth-1 is the valid bit.
- MulticastBitPos, 253, set = multicast packet.
- IndexPos, 128, LSB of the multicast table index field.
- IndexWidth, 8, index field width; the table has 2^IndexWidth entries.
- ExitPos, 160, LSB of the unicast exit-port field.
- ExitWidth, 4, exit field width; legal values 0..6.
- NumPorts, 7, number of output ports (fixed at 7).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- in  in  DataWidth  input packet; valid when bit DataWidth-1 = 1
- in_avail  out  1  block can accept `in` this cycle (combinational)
- out_avail  in  7  per-port downstream not-full; bit order local, yneg, ypos, xpos, xneg, zpos, zneg
- out_local, out_yneg, out_ypos, out_xpos, out_xneg, out_zpos, out_zneg  out  DataWidth each  registered output packets
- cfg_we  in  1  multicast table write enable
- cfg_addr  in  IndexWidth  table write address
- cfg_mask  in  7  table write data (port mask)
- drop_cnt  out  16  dropped-packet counter; wraps at 2^16

Behaviour:
- Reset (rst=0, async):
  - All out_* = 0; drop_cnt = 0.
  - Stage A and stage S invalid; every multicast table entry = 0.
  - Takes effect mid-operation: any packet in flight is discarded, with no partial copies issued after reset.
- Accept: packet taken on a rising edge when in[DataWidth-1]=1 and in_avail=1. Valid packets presented while in_avail=0 are not taken; upstream holds them.
- Stage A (lookup):
  - Register the accepted packet.
  - Read table[in[IndexPos+:IndexWidth]] synchronously at the same edge.
  - Read-first: a cfg write to the same address on the same edge returns the old mask.
- Stage S (send), entered when S is free:
  - Multicast: remaining mask = table mask.
  - Unicast: remaining mask = one-hot(exit field).
- Drops: exit field > 6, or a multicast mask of 0, is dropped at the A→S transition. drop_cnt increments by 1 and S is not occupied.
- Each S cycle:
  - grant = remaining & out_avail.
  - At the next edge: out_p = packet for each granted p; out_p = 0 for every other p; remaining &= ~grant.
  - Packet bits are copied unchanged.
- S free next cycle = S invalid, or (remaining & ~out_avail) == 0.
- in_avail = ~A_valid | S_free_next. Sustained throughput is 1 packet per clock when all targeted ports are available.
- Latency: first copies are visible after the 2nd rising edge following the accept edge (accept edge E0, A→S at E1, out_* at E2).
- Each out_* holds a given packet for exactly one cycle; there are no duplicate copies per port.
- Table isolation: a cfg write during S does not alter the captured remaining mask.
- Ordering: per output port, packets leave in acceptance order. No packet overtakes another, because only one packet is ever in S.
- drop_cnt wraps from 0xFFFF to 0x0000.

Test Plan:
- Unicast: accept a packet with exit=3 and all out_avail=1 → out_xpos equals the packet after 2 edges; the other six outputs are 0; drop_cnt=0.
- Multicast full fan-out: write table[5]=7'b1010101, then send a multicast packet with index 5 and all ports available → out_local, ypos, xneg and zneg carry the packet in the same cycle; the others are 0.
- Partial replication: table[9]=7'b0000111, out_avail=7'b0000101 for 3 cycles, then 7'b1111111 → local and ypos copies emit first; yneg emits after release; in_avail=0 while A and S are both held; each port gets exactly 1 copy.
- Drops: unicast exit=7 and multicast index with mask 0 → no output on any port; drop_cnt=2. Pre-load drop_cnt at 0xFFFF and drop once → 0x0000.
- Back-to-back streaming: 16 consecutive unicast packets alternating exit 0/6 with all ports available → in_avail stays 1; outputs appear one per cycle in order.
- Reset mid-operation: assert rst=0 while a multicast packet is blocked in S → all out_* are 0 immediately. After release, table reads 0 and no residual copy appears.
